// File: rtl/lc3_program_loader.sv
// LC-3 program loader: takes an origin word and then program words from a valid/ready stream.
// It writes each word to memory through the MAR/MDR special inputs, then reports done and start_pc.
module lc3_program_loader #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned WE_CYCLES = 1,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] MARSpcIn,
    output logic              ldMARSpcIn,
    output logic              ldMAR,
    output logic [DATA_W-1:0] MDRSpcIn,
    output logic [1:0]        selMDR,
    output logic              ldMDR,
    output logic              memWE,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] start_pc,
    output logic [DATA_W-1:0] word_count
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0]  WE_LAST  = CNT_W'(WE_CYCLES - 1);
    localparam logic [DATA_W-1:0] MAX_CNT  = DATA_W'(MAX_WORDS);
    localparam logic [1:0]        SEL_SPC  = 2'b11;

    typedef enum logic [2:0] {
        S_ORIG,
        S_WAIT,
        S_MAR,
        S_MDR,
        S_WE,
        S_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic [CNT_W-1:0]  we_cnt;
    logic [DATA_W-1:0] count_next;

    assign count_next = word_count + DATA_W'(1);

    // Outputs are registered together with the state so they always match its Moore decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_ORIG;
            addr_q     <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            we_cnt     <= '0;
            in_ready   <= 1'b1;
            MARSpcIn   <= '0;
            ldMARSpcIn <= 1'b0;
            ldMAR      <= 1'b0;
            MDRSpcIn   <= '0;
            selMDR     <= 2'b00;
            ldMDR      <= 1'b0;
            memWE      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            start_pc   <= '0;
            word_count <= '0;
        end else begin
            case (state)
                S_ORIG: begin
                    if (in_valid && in_ready) begin
                        addr_q   <= in_data;
                        start_pc <= in_data;
                        busy     <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (in_valid && in_ready) begin
                        data_q     <= in_data;
                        last_q     <= in_last;
                        in_ready   <= 1'b0;
                        MARSpcIn   <= addr_q;
                        ldMARSpcIn <= 1'b1;
                        ldMAR      <= 1'b1;
                        state      <= S_MAR;
                    end
                end
                S_MAR: begin
                    ldMAR    <= 1'b0;
                    MDRSpcIn <= data_q;
                    selMDR   <= SEL_SPC;
                    ldMDR    <= 1'b1;
                    state    <= S_MDR;
                end
                S_MDR: begin
                    ldMDR      <= 1'b0;
                    ldMARSpcIn <= 1'b0;
                    memWE      <= 1'b1;
                    we_cnt     <= '0;
                    state      <= S_WE;
                end
                S_WE: begin
                    if (we_cnt == WE_LAST) begin
                        // Word committed: advance the address (wrapping) and release the bus.
                        addr_q     <= addr_q + DATA_W'(1);
                        word_count <= count_next;
                        memWE      <= 1'b0;
                        MARSpcIn   <= '0;
                        MDRSpcIn   <= '0;
                        selMDR     <= 2'b00;
                        we_cnt     <= '0;
                        if (last_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (count_next == MAX_CNT) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            error <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_WAIT;
                        end
                    end else begin
                        we_cnt <= we_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_ORIG;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_program_loader.sv
// Randomized scoreboard bench for lc3_program_loader: expected memory writes come from a
// stream-level model and are compared by an independent monitor on every memWE pulse.
module tb_lc3_program_loader;

    localparam int unsigned WE   = 3;
    localparam int unsigned MAXW = 4;
    localparam time         PER  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] MARSpcIn;
    logic        ldMARSpcIn;
    logic        ldMAR;
    logic [15:0] MDRSpcIn;
    logic [1:0]  selMDR;
    logic        ldMDR;
    logic        memWE;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] start_pc;
    logic [15:0] word_count;

    always #(PER/2) clk = ~clk;

    lc3_program_loader #(.DATA_W(16), .WE_CYCLES(WE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .MARSpcIn(MARSpcIn), .ldMARSpcIn(ldMARSpcIn), .ldMAR(ldMAR),
        .MDRSpcIn(MDRSpcIn), .selMDR(selMDR), .ldMDR(ldMDR), .memWE(memWE),
        .busy(busy), .done(done), .error(error),
        .start_pc(start_pc), .word_count(word_count)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    time         hs_q[$];
    time         rise_t[$];
    logic [15:0] stim[$];

    logic        prev_we = 1'b0;
    int          we_len  = 0;
    logic [15:0] held_mar, held_mdr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every memWE pulse must match the next expected write and obey the timing rules.
    always @(negedge clk) begin
        if (reset) begin
            prev_we <= 1'b0;
            we_len  <= 0;
        end else begin
            if (memWE && !prev_we) begin
                rise_t.push_back($time - PER/2);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(MARSpcIn), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(MARSpcIn), 32'(e.addr));
                    chk("wr_data", 32'(MDRSpcIn), 32'(e.data));
                    chk("wr_selMDR", 32'(selMDR), 32'd3);
                end
                if (hs_q.size() != 0) begin
                    time t;
                    t = hs_q.pop_front();
                    chk("hs_to_we_latency", 32'($time - PER/2 - t), 32'(2*PER));
                end
                held_mar <= MARSpcIn;
                held_mdr <= MDRSpcIn;
                we_len   <= 1;
            end else if (memWE) begin
                chk("mar_stable", 32'(MARSpcIn), 32'(held_mar));
                chk("mdr_stable", 32'(MDRSpcIn), 32'(held_mdr));
                we_len <= we_len + 1;
            end else if (prev_we) begin
                chk("we_pulse_len", 32'(we_len), 32'(WE));
            end
            if (memWE || ldMAR || ldMDR || ldMARSpcIn) begin
                chk("ready_low_in_write", 32'(in_ready), 32'd0);
            end else begin
                chk("idle_bus", {MARSpcIn, MDRSpcIn}, 32'd0);
            end
            prev_we <= memWE;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        hs_q.delete();
        rise_t.delete();
    endtask

    // Present one word and hold it until it transfers, done rises, or the bound expires.
    task automatic send(input logic [15:0] d, input bit last, input bit is_origin, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done) return;
            if (in_ready) begin
                @(posedge clk);
                if (!is_origin) hs_q.push_back($time);
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Load origin + stim[] and check end-of-load status against a stream-level model.
    task automatic run_load(input logic [15:0] org, input bit use_last, input bit bp);
        int          n, cnt, acc;
        bit          err, ok;
        logic [15:0] addr;
        n    = stim.size();
        addr = org;
        cnt  = 0;
        err  = 1'b0;
        do_reset();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({addr, stim[i]});
            addr = addr + 16'd1;
            cnt++;
            if (use_last && i == n - 1) break;
            if (cnt == int'(MAXW)) begin
                err = 1'b1;
                break;
            end
        end
        send(org, 1'b1, 1'b1, ok);
        chk("origin_accepted", 32'(ok), 32'd1);
        acc = 0;
        for (int i = 0; i < n; i++) begin
            send(stim[i], use_last && (i == n - 1), 1'b0, ok);
            if (!ok) break;
            acc++;
            if (!bp) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("accepted_words", 32'(acc), 32'(cnt));
        chk("error_flag", 32'(error), 32'(err));
        chk("start_pc", 32'(start_pc), 32'(org));
        chk("word_count", 32'(word_count), 32'(cnt));
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("ready_after_done", 32'(in_ready), 32'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        if (bp) begin
            for (int k = 1; k < rise_t.size(); k++)
                chk("word_period", 32'(rise_t[k] - rise_t[k-1]), 32'((3 + WE) * PER));
        end
    endtask

    initial begin
        bit ok;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        do_reset();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", {28'd0, busy, done, error, memWE}, 32'd0);
        chk("rst_ctrl", {26'd0, ldMARSpcIn, ldMAR, ldMDR, selMDR, 1'b0}, 32'd0);
        chk("rst_words", {start_pc, word_count}, 32'd0);

        // Reset during a write cycle.
        send(16'h3000, 1'b0, 1'b1, ok);
        exp_q.push_back({16'h3000, 16'hE203});
        send(16'hE203, 1'b0, 1'b0, ok);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !memWE; i++) @(negedge clk);
        chk("reached_we", 32'(memWE), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("midwr_rst_we", 32'(memWE), 32'd0);
        chk("midwr_rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("midwr_rst_count", 32'(word_count), 32'd0);
        chk("midwr_rst_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        hs_q.delete();

        stim = '{16'hE203, 16'h3200};
        run_load(16'h3000, 1'b1, 1'b0);
        stim = '{16'h1234, 16'hABCD};
        run_load(16'hFFFF, 1'b1, 1'b1);
        stim = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        run_load(16'h4000, 1'b0, 1'b1);
        stim = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        run_load(16'h5000, 1'b1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            bit ovf;
            int n;
            ovf = ($urandom_range(0, 3) == 0);
            n   = ovf ? int'(MAXW) + 1 : int'($urandom_range(1, MAXW));
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
            run_load(16'($urandom), !ovf, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
